// File: rtl/spi_xfer_pkg.sv
// Shared types and width helpers for the per-sample SPI frame engine.
package spi_xfer_pkg;

   localparam int unsigned DEF_DATA_W    = 16;
   localparam int unsigned DEF_SCLK_HALF = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      SHIFT = 2'd2,
      HOLD  = 2'd3
   } xfer_state_t;

   // Half-period counter width; a single-cycle half period still needs one bit.
   function automatic int unsigned half_cnt_w(input int unsigned sclk_half);
      return (sclk_half > 1) ? $clog2(sclk_half) : 1;
   endfunction

   function automatic int unsigned bit_cnt_w(input int unsigned data_w);
      return $clog2(data_w + 1);
   endfunction

endpackage

// File: rtl/sclk_phase_gen.sv
// Half-period timer: while enabled, pulses o_half_tick_c on the last cycle of every
// SCLK_HALF-cycle window. Held at zero while i_clr is high.
module sclk_phase_gen
   import spi_xfer_pkg::*;
#(
   parameter int unsigned SCLK_HALF = DEF_SCLK_HALF
) (
   input  logic i_clk,
   input  logic i_nrst,
   input  logic i_en,
   input  logic i_clr,
   output logic o_half_tick_c
);

   localparam int unsigned     CNT_W = half_cnt_w(SCLK_HALF);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(SCLK_HALF - 1);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge i_clk) begin
      if (!i_nrst || i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CNT_W'(1);
      end
   end

   assign o_half_tick_c = i_en && (r_cnt == LAST);

endmodule

// File: rtl/spi_sample_xfer.sv
// Per-sample mode-0 SPI master: one start runs one full-duplex DATA_W-bit frame.
// Optional build macro SPI_XFER_LOOPBACK_EN adds a loopback input (mosi -> rx path).
module spi_sample_xfer
   import spi_xfer_pkg::*;
#(
   parameter int unsigned DATA_W    = DEF_DATA_W,
   parameter int unsigned SCLK_HALF = DEF_SCLK_HALF
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              start,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              miso,
`ifdef SPI_XFER_LOOPBACK_EN
   input  logic              loopback,
`endif
   output logic              cs_n,
   output logic              sclk,
   output logic              mosi,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   output logic              busy,
   output logic              overrun
);

   localparam int unsigned     BCNT_W   = bit_cnt_w(DATA_W);
   localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(DATA_W);

   xfer_state_t       r_state,    w_state_nxt;
   logic [DATA_W-1:0] r_tx_sr,    w_tx_sr_nxt;
   logic [DATA_W-1:0] r_rx_sr,    w_rx_sr_nxt;
   logic [BCNT_W-1:0] r_bit_cnt,  w_bit_cnt_nxt;
   logic              r_phase_hi, w_phase_hi_nxt;
   logic              r_cs_n,     w_cs_n_nxt;
   logic              r_sclk,     w_sclk_nxt;
   logic              r_mosi,     w_mosi_nxt;
   logic [DATA_W-1:0] r_rx_data,  w_rx_data_nxt;
   logic              r_rx_valid, w_rx_valid_nxt;
   logic              r_busy,     w_busy_nxt;
   logic              r_overrun,  w_overrun_nxt;
   logic              w_half_tick;
   logic              w_sample;

   sclk_phase_gen #(
      .SCLK_HALF (SCLK_HALF)
   ) u_phase (
      .i_clk         (clk),
      .i_nrst        (nrst),
      .i_en          (r_state != IDLE),
      .i_clr         (r_state == IDLE),
      .o_half_tick_c (w_half_tick)
   );

`ifdef SPI_XFER_LOOPBACK_EN
   assign w_sample = loopback ? r_mosi : miso;
`else
   assign w_sample = miso;
`endif

   always_ff @(posedge clk) begin
      if (!nrst) begin
         r_state    <= IDLE;
         r_tx_sr    <= '0;
         r_rx_sr    <= '0;
         r_bit_cnt  <= '0;
         r_phase_hi <= 1'b0;
         r_cs_n     <= 1'b1;
         r_sclk     <= 1'b0;
         r_mosi     <= 1'b0;
         r_rx_data  <= '0;
         r_rx_valid <= 1'b0;
         r_busy     <= 1'b0;
         r_overrun  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_tx_sr    <= w_tx_sr_nxt;
         r_rx_sr    <= w_rx_sr_nxt;
         r_bit_cnt  <= w_bit_cnt_nxt;
         r_phase_hi <= w_phase_hi_nxt;
         r_cs_n     <= w_cs_n_nxt;
         r_sclk     <= w_sclk_nxt;
         r_mosi     <= w_mosi_nxt;
         r_rx_data  <= w_rx_data_nxt;
         r_rx_valid <= w_rx_valid_nxt;
         r_busy     <= w_busy_nxt;
         r_overrun  <= w_overrun_nxt;
      end
   end

   // Pin values are computed one cycle ahead so every output is a flop.
   always_comb begin
      w_state_nxt    = r_state;
      w_tx_sr_nxt    = r_tx_sr;
      w_rx_sr_nxt    = r_rx_sr;
      w_bit_cnt_nxt  = r_bit_cnt;
      w_phase_hi_nxt = r_phase_hi;
      w_cs_n_nxt     = r_cs_n;
      w_sclk_nxt     = r_sclk;
      w_mosi_nxt     = r_mosi;
      w_rx_data_nxt  = r_rx_data;
      w_rx_valid_nxt = 1'b0;
      w_overrun_nxt  = r_overrun | (start && (r_state != IDLE));

      case (r_state)
         IDLE: begin
            if (start) begin
               w_state_nxt    = SETUP;
               w_tx_sr_nxt    = tx_data;
               w_rx_sr_nxt    = '0;
               w_bit_cnt_nxt  = '0;
               w_phase_hi_nxt = 1'b0;
               w_cs_n_nxt     = 1'b0;
               w_sclk_nxt     = 1'b0;
               w_mosi_nxt     = tx_data[DATA_W-1];
            end
         end
         SETUP: begin
            if (w_half_tick) begin
               w_state_nxt    = SHIFT;
               w_sclk_nxt     = 1'b1;
               w_phase_hi_nxt = 1'b1;
               w_rx_sr_nxt    = {r_rx_sr[DATA_W-2:0], w_sample};
            end
         end
         SHIFT: begin
            if (w_half_tick) begin
               if (r_phase_hi) begin
                  // Falling edge: advance the transmit word.
                  w_sclk_nxt     = 1'b0;
                  w_phase_hi_nxt = 1'b0;
                  w_tx_sr_nxt    = r_tx_sr << 1;
                  w_mosi_nxt     = r_tx_sr[DATA_W-2];
                  w_bit_cnt_nxt  = r_bit_cnt + BCNT_W'(1);
               end else if (r_bit_cnt == LAST_BIT) begin
                  w_state_nxt    = HOLD;
               end else begin
                  w_sclk_nxt     = 1'b1;
                  w_phase_hi_nxt = 1'b1;
                  w_rx_sr_nxt    = {r_rx_sr[DATA_W-2:0], w_sample};
               end
            end
         end
         HOLD: begin
            if (w_half_tick) begin
               w_state_nxt    = IDLE;
               w_cs_n_nxt     = 1'b1;
               w_mosi_nxt     = 1'b0;
               w_rx_data_nxt  = r_rx_sr;
               w_rx_valid_nxt = 1'b1;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase

      w_busy_nxt = (w_state_nxt != IDLE);
   end

   assign cs_n     = r_cs_n;
   assign sclk     = r_sclk;
   assign mosi     = r_mosi;
   assign rx_data  = r_rx_data;
   assign rx_valid = r_rx_valid;
   assign busy     = r_busy;
   assign overrun  = r_overrun;

endmodule

// File: tb/tb_spi_sample_xfer.sv
// Directed scoreboard bench for spi_sample_xfer (16-bit/half=2 instance plus an 8-bit/half=1 instance).
module tb_spi_sample_xfer;

   localparam int DW   = 16;
   localparam int SH   = 2;
   localparam int N    = SH * (2 * DW + 2);
   localparam int DW_B = 8;
   localparam int SH_B = 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            nrst, start, miso = 1'b0;
   logic [DW-1:0]   tx_data;
   logic            cs_n, sclk, mosi, rx_valid, busy, overrun;
   logic [DW-1:0]   rx_data;
`ifdef SPI_XFER_LOOPBACK_EN
   logic            loopback = 1'b0;
   logic            loopback_b = 1'b0;
`endif

   logic            start_b;
   logic [DW_B-1:0] tx_b;
   logic            miso_b = 1'b0;
   logic            cs_n_b, sclk_b, mosi_b, rx_valid_b, busy_b, overrun_b;
   logic [DW_B-1:0] rx_data_b;

   spi_sample_xfer #(.DATA_W(DW), .SCLK_HALF(SH)) u_dut (
      .clk(clk), .nrst(nrst), .start(start), .tx_data(tx_data), .miso(miso),
`ifdef SPI_XFER_LOOPBACK_EN
      .loopback(loopback),
`endif
      .cs_n(cs_n), .sclk(sclk), .mosi(mosi), .rx_data(rx_data),
      .rx_valid(rx_valid), .busy(busy), .overrun(overrun)
   );

   spi_sample_xfer #(.DATA_W(DW_B), .SCLK_HALF(SH_B)) u_dut_b (
      .clk(clk), .nrst(nrst), .start(start_b), .tx_data(tx_b), .miso(miso_b),
`ifdef SPI_XFER_LOOPBACK_EN
      .loopback(loopback_b),
`endif
      .cs_n(cs_n_b), .sclk(sclk_b), .mosi(mosi_b), .rx_data(rx_data_b),
      .rx_valid(rx_valid_b), .busy(busy_b), .overrun(overrun_b)
   );

   typedef struct {
      logic [DW-1:0] rx;
      logic [DW-1:0] tx;
      int            t0;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_pass   = 0;
   int   n_fail   = 0;
   int   tb_cyc   = 0;

   always @(posedge clk) tb_cyc <= tb_cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // ADC model and frame monitor for the 16-bit instance
   logic          prev_sclk = 1'b0, prev_mosi = 1'b0;
   logic [DW-1:0] mosi_cap = '0;
   logic [DW-1:0] slave_word = '0;
   logic          slave_ones = 1'b0;
   int            s_idx = 0;
   int            low_cnt = 0;

   always @(negedge clk) begin
      if (rx_valid === 1'b1) begin
         if (sb.size() == 0) begin
            check("rx_valid_unexpected", 32'(1), 32'(0));
         end else begin
            mon_e = sb.pop_front();
            check("rx_data", 32'(rx_data), 32'(mon_e.rx));
            check("mosi_word", 32'(mosi_cap), 32'(mon_e.tx));
            check("rx_valid_cycle", 32'(tb_cyc - mon_e.t0 + 1), 32'(N + 1));
            check("cs_n_low_len", 32'(low_cnt), 32'(N));
         end
      end
      if (cs_n !== 1'b0) low_cnt = 0;
      else               low_cnt++;
      if (prev_sclk === 1'b0 && sclk === 1'b1) begin
         check("mosi_stable_at_rise", 32'(mosi), 32'(prev_mosi));
         mosi_cap = {mosi_cap[DW-2:0], mosi};
      end
      if (cs_n !== 1'b0) begin
         s_idx = 0;
         miso  = slave_ones | slave_word[DW-1];
      end else if (prev_sclk === 1'b1 && sclk === 1'b0) begin
         s_idx++;
         miso = slave_ones | ((s_idx < DW) ? slave_word[DW-1-s_idx] : 1'b0);
      end
      prev_sclk = sclk;
      prev_mosi = mosi;
   end

   task automatic kick(input logic [DW-1:0] tx, input logic [DW-1:0] rxw);
      exp_t e;
      slave_word = rxw;
      tx_data    = tx;
      start      = 1'b1;
      e.rx = rxw;
      e.tx = tx;
      e.t0 = tb_cyc + 1;
      sb.push_back(e);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_valid(input int bound);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < bound && !seen; i++) begin
         @(posedge clk); #1;
         seen = rx_valid;
      end
      check("rx_valid_seen", 32'(seen), 32'(1));
   endtask

   logic [DW-1:0] b2b_words [3] = '{16'hDEAD, 16'h0001, 16'h8000};
   int t0b, first_low, last_low, valid_r, last_rise, rises, highs, r, rv_cnt;
   logic prev_b;

   initial begin
      nrst = 1'b0; start = 1'b0; tx_data = '0; start_b = 1'b0; tx_b = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_cs_n", 32'(cs_n), 32'(1));
      check("rst_sclk", 32'(sclk), 32'(0));
      check("rst_mosi", 32'(mosi), 32'(0));
      check("rst_rx_data", 32'(rx_data), 32'(0));
      check("rst_rx_valid", 32'(rx_valid), 32'(0));
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_overrun", 32'(overrun), 32'(0));
      nrst = 1'b1;
      @(posedge clk); #1;

      // basic frame
      kick(16'hA5C3, 16'h1234);
      check("busy_in_frame", 32'(busy), 32'(1));
      wait_valid(N + 10);

      // back-to-back frames started in the rx_valid cycle
      for (int k = 0; k < 3; k++) begin
         check("gap_cs_n", 32'(cs_n), 32'(1));
         check("gap_busy", 32'(busy), 32'(0));
         kick(~b2b_words[k], b2b_words[k]);
         wait_valid(N + 10);
      end
      check("b2b_no_overrun", 32'(overrun), 32'(0));

      // start while busy
      @(posedge clk); #1;
      kick(16'h0F0F, 16'hC0DE);
      repeat (9) @(posedge clk);
      #1;
      tx_data = 16'hFFFF; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("overrun_set", 32'(overrun), 32'(1));
      check("busy_after_ignored", 32'(busy), 32'(1));
      wait_valid(N + 10);
      @(posedge clk); #1;
      kick(16'h8001, 16'h7FFE);
      wait_valid(N + 10);
      check("overrun_sticky", 32'(overrun), 32'(1));

      // reset in the middle of a frame
      @(posedge clk); #1;
      kick(16'h3C3C, 16'h5A5A);
      repeat (29) @(posedge clk);
      #1;
      nrst = 1'b0;
      @(posedge clk); #1;
      sb.delete();
      check("midrst_cs_n", 32'(cs_n), 32'(1));
      check("midrst_sclk", 32'(sclk), 32'(0));
      check("midrst_rx_data", 32'(rx_data), 32'(0));
      check("midrst_busy", 32'(busy), 32'(0));
      check("midrst_overrun", 32'(overrun), 32'(0));
      nrst = 1'b1;
      rv_cnt = 0;
      for (int i = 0; i < N + 10; i++) begin
         @(posedge clk); #1;
         if (rx_valid) rv_cnt++;
      end
      check("midrst_no_rx_valid", 32'(rv_cnt), 32'(0));
      kick(16'h1357, 16'h2468);
      wait_valid(N + 10);

`ifdef SPI_XFER_LOOPBACK_EN
      @(posedge clk); #1;
      loopback   = 1'b1;
      slave_ones = 1'b1;
      kick(16'hBEEF, 16'hBEEF);
      wait_valid(N + 10);
      loopback   = 1'b0;
      slave_ones = 1'b0;
`endif

      // 8-bit, single-cycle half period instance
      @(posedge clk); #1;
      tx_b = 8'hFF; start_b = 1'b1; t0b = tb_cyc + 1;
      @(posedge clk); #1;
      start_b = 1'b0;
      first_low = -1; last_low = -1; valid_r = -1; last_rise = -1;
      rises = 0; highs = 0; prev_b = 1'b0;
      for (int i = 0; i < 25; i++) begin
         r = tb_cyc - t0b + 1;
         if (!cs_n_b) begin
            if (first_low < 0) first_low = r;
            last_low = r;
         end
         if (rx_valid_b) valid_r = r;
         if (sclk_b && !prev_b) begin
            if (last_rise >= 0) check("b_sclk_period", 32'(r - last_rise), 32'(2));
            last_rise = r;
            rises++;
         end
         if (sclk_b) highs++;
         prev_b = sclk_b;
         @(posedge clk); #1;
      end
      check("b_cs_n_first", 32'(first_low), 32'(1));
      check("b_cs_n_last", 32'(last_low), 32'(2 * SH_B * DW_B + 2 * SH_B));
      check("b_rx_valid_cycle", 32'(valid_r), 32'(19));
      check("b_sclk_rises", 32'(rises), 32'(DW_B));
      check("b_sclk_high_cycles", 32'(highs), 32'(DW_B));
      check("b_rx_data", 32'(rx_data_b), 32'(0));

      check("sb_drained", 32'(sb.size()), 32'(0));
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
